mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-store bus, in parallel with the data memory.
- Consumes the core's writedata, dataadr and memwrite outputs, and captures stores to its TX address into a small FIFO.
- Serialises each byte as 8N1 on a single tx line.
- Exposes status flags for board pins and the testbench. There is no read path back to the core.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- CLKS_PER_BIT, 16, clk cycles per serial bit (at least 2).
- TX_ADDR, 32'hFFFF_FF00, store address that enqueues writedata[7:0].
- CTRL_ADDR, 32'hFFFF_FF04, store address where writedata[0]=1 clears overflow.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- dataadr  in  32  store address from the core.
- writedata  in  32  store data from the core.
- memwrite  in  1  store strobe from the core.
- tx  out  1  serial output, idle high.
- busy  out  1  FSM not in IDLE.
- empty  out  1  FIFO count == 0.
- full  out  1  FIFO count == DEPTH.
- overflow  out  1  sticky flag: a store to TX_ADDR was dropped.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Design rule: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clock edge) forces:
  - tx=1, busy=0, empty=1, full=0, overflow=0, count=0.
  - FSM to IDLE; FIFO pointers and bit/baud counters to 0.
  - This applies mid-frame too: the frame aborts, tx returns high the next cycle, and FIFO contents are discarded.
- Push:
  - push = memwrite && dataadr==TX_ADDR (full 32-bit compare; no byte-lane decode).
  - Accepted when count<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- Pop:
  - Occurs when the FSM loads a byte (IDLE with !empty, or the last STOP cycle with !empty).
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Overflow clear: a store to CTRL_ADDR with writedata[0]=1 clears overflow. If a drop happens in the same cycle, the set wins.
- FSM states are IDLE, START, DATA, STOP; each bit is held for CLKS_PER_BIT cycles by a baud counter.
  - IDLE: tx=1. If !empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]; 8 bits, LSB first; shift right after each bit period. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, if !empty pop and go to START (zero-gap back-to-back frames); else go to IDLE.
- Latency:
  - A store captured at edge E into an empty FIFO with the FSM idle gives count=1 after E.
  - Pop at edge E+1 (count=0, busy=1); tx falls after E+1.
- Frame timing: each frame is exactly 10*CLKS_PER_BIT cycles; consecutive queued bytes have no idle cycles between frames.
- Output registering: tx is registered (glitch-free); flags are derived from registered state.
- Other addresses are ignored, including memwrite=0 with a matching dataadr.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
1. Hold reset=0 for 2 cycles with memwrite=1 to TX_ADDR -> tx=1, count=0, empty=1, overflow=0 throughout.
2. Store 32'h0000_00A5 to TX_ADDR once:
   - count=1 after that edge; busy=1 after the next edge.
   - tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
   - Then busy=0 and empty=1.
3. Store 0x11,0x22,0x33,0x44,0x55,0x66 on consecutive cycles:
   - 0x11 pops one cycle after its store and bytes 0x22–0x55 fill the FIFO (count=4, full=1).
   - 0x66 is dropped and overflow=1.
   - tx carries 0x11..0x55 back-to-back in 200 cycles with no idle-high gaps.
4. With overflow=1, store 1 to CTRL_ADDR -> overflow=0 next cycle. A store of 0 to CTRL_ADDR leaves overflow unchanged.
5. With full=1, store to TX_ADDR in the cycle STOP ends -> that byte is accepted (push and pop together), count stays 4, overflow stays 0.
6. Pull reset low during DATA bit 3 of 0xFF with 2 bytes queued -> next cycle tx=1, busy=0, count=0. No further frames until a new store.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Store-mapped 8N1 UART transmitter: stores to TX_ADDR queue a byte, the FSM shifts it out LSB first.
// Byte pops one cycle after capture into an idle unit; a full FIFO drops the store and sets sticky overflow.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [W-1:0]             in_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [W-1:0]             out_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign in_rdy  = (count != CW'(DEPTH)) || pop;
    assign push    = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mmio_uart_tx #(
    parameter int          DEPTH        = 4,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] TX_ADDR      = 32'hFFFF_FF00,
    parameter logic [31:0] CTRL_ADDR    = 32'hFFFF_FF04
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              dataadr,
    input  logic [31:0]              writedata,
    input  logic                     memwrite,
    output logic                     tx,
    output logic                     busy,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bitn;
    logic [7:0]    shift;
    logic          tx_r;
    logic          ovf_r;

    logic          push_req;
    logic          push_rdy;
    logic          drop;
    logic          clr;
    logic          baud_last;
    logic          fifo_vld;
    logic          fifo_rdy;
    logic [7:0]    fifo_dat;
    logic          unused_wd;

    assign push_req  = memwrite && (dataadr == TX_ADDR);
    assign drop      = push_req && !push_rdy;
    assign clr       = memwrite && (dataadr == CTRL_ADDR) && writedata[0];
    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
    // The FSM takes a byte only when idle or on the final stop cycle (gapless frames).
    assign fifo_rdy  = (state == IDLE) || ((state == STOP) && baud_last);
    assign unused_wd = ^writedata[31:8];

    fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (push_req),
        .in_rdy  (push_rdy),
        .in_dat  (writedata[7:0]),
        .out_vld (fifo_vld),
        .out_rdy (fifo_rdy),
        .out_dat (fifo_dat),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            baud  <= '0;
            bitn  <= '0;
            shift <= '0;
            tx_r  <= 1'b1;
            ovf_r <= 1'b0;
        end else begin
            if (drop) begin
                ovf_r <= 1'b1;
            end else if (clr) begin
                ovf_r <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fifo_vld) begin
                        shift <= fifo_dat;
                        baud  <= '0;
                        tx_r  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud  <= '0;
                        bitn  <= '0;
                        tx_r  <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bitn == 3'd7) begin
                            tx_r  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitn  <= bitn + 3'd1;
                            shift <= shift >> 1;
                            tx_r  <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (fifo_vld) begin
                            shift <= fifo_dat;
                            tx_r  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx       = tx_r;
    assign busy     = (state != IDLE);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign overflow = ovf_r;
endmodule
